simple_merger: RTL

- 4-to-1 collector; the return direction of the 1-to-4 simple router.
- Four sources each hand it one word at a time over a valid/ready handshake. Each word is held in a per-source one-entry buffer.
- A round-robin arbiter drains the buffers into one registered output stream. Each output word is tagged with a 2-bit source address that uses the same encoding as the router's addr input.
- Sits in front of a single downstream consumer that applies backpressure through dout_rdy.

---
 rtl/simple_merger_pkg.sv | 7 +
 rtl/simple_merger_if.sv | 27 ++
 rtl/simple_merger_rr_arbiter4.sv | 27 ++
 rtl/simple_merger.sv | 75 +++++++
 4 files changed

// File: rtl/simple_merger_pkg.sv
// rtl/simple_merger_pkg.sv - shared constants and types for the 4-to-1 merger
package simple_merger_pkg;
  localparam int NUM_SRC = 4;
  localparam int ADDR_W  = 2;

  typedef logic [ADDR_W-1:0] src_idx_t;
endpackage

// File: rtl/simple_merger_if.sv
// rtl/simple_merger_if.sv - source-side inputs and merged output stream of the merger
interface simple_merger_if #(
  parameter int DATA_WIDTH = 32
);
  import simple_merger_pkg::*;

  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] din1;
  logic [DATA_WIDTH-1:0] din2;
  logic [DATA_WIDTH-1:0] din3;
  logic [NUM_SRC-1:0]    din_en;
  logic [NUM_SRC-1:0]    din_rdy;
  logic [DATA_WIDTH-1:0] dout;
  src_idx_t              dout_addr;
  logic                  dout_en;
  logic                  dout_rdy;

  modport master (
    output din0, din1, din2, din3, din_en, dout_rdy,
    input  din_rdy, dout, dout_addr, dout_en
  );

  modport slave (
    input  din0, din1, din2, din3, din_en, dout_rdy,
    output din_rdy, dout, dout_addr, dout_en
  );
endinterface

// File: rtl/simple_merger_rr_arbiter4.sv
// rtl/simple_merger_rr_arbiter4.sv - combinational 4-way round-robin grant starting at i_ptr
module rr_arbiter4
  import simple_merger_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_req,
  input  src_idx_t           i_ptr,
  output logic               o_gnt_vld,
  output src_idx_t           o_gnt_idx
);

  src_idx_t w_idx;

  // Scan from the farthest offset down so the nearest requester to i_ptr wins.
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_idx = '0;
    w_idx     = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_idx = i_ptr + src_idx_t'(k);
      if (i_req[w_idx]) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/simple_merger.sv
// rtl/simple_merger.sv - four one-entry source buffers drained round-robin into one registered stream
module simple_merger
  import simple_merger_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  simple_merger_if.slave   bus
);

  logic [DATA_WIDTH-1:0] r_buf [NUM_SRC];
  logic [NUM_SRC-1:0]    r_buf_v;
  logic [DATA_WIDTH-1:0] r_dout;
  src_idx_t              r_dout_addr;
  logic                  r_dout_en;
  src_idx_t              r_rr_ptr;

  logic [DATA_WIDTH-1:0] w_din [NUM_SRC];
  logic                  w_out_free;
  logic                  w_gnt_vld;
  src_idx_t              w_gnt_idx;

  assign w_din[0] = bus.din0;
  assign w_din[1] = bus.din1;
  assign w_din[2] = bus.din2;
  assign w_din[3] = bus.din3;

  assign w_out_free = ~r_dout_en | bus.dout_rdy;

  rr_arbiter4 u_arb (
    .i_req     (r_buf_v),
    .i_ptr     (r_rr_ptr),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_idx (w_gnt_idx)
  );

  // A granted buffer is always full, so its din_rdy was low and the accept loop cannot touch it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_buf_v     <= '0;
      r_dout      <= '0;
      r_dout_addr <= '0;
      r_dout_en   <= 1'b0;
      r_rr_ptr    <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_buf[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bus.din_en[i] && !r_buf_v[i]) begin
          r_buf[i]   <= w_din[i];
          r_buf_v[i] <= 1'b1;
        end
      end
      if (w_out_free) begin
        if (w_gnt_vld) begin
          r_dout             <= r_buf[w_gnt_idx];
          r_dout_addr        <= w_gnt_idx;
          r_dout_en          <= 1'b1;
          r_buf_v[w_gnt_idx] <= 1'b0;
          r_rr_ptr           <= src_idx_t'(w_gnt_idx + 2'd1);
        end else begin
          r_dout      <= '0;
          r_dout_addr <= '0;
          r_dout_en   <= 1'b0;
        end
      end
    end
  end

  assign bus.din_rdy   = ~r_buf_v;
  assign bus.dout      = r_dout;
  assign bus.dout_addr = r_dout_addr;
  assign bus.dout_en   = r_dout_en;

endmodule
